// File: rtl/adc_pkg.sv
// Shared types and frame geometry for the serial ADC reader.
package adc_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned LEAD_BITS  = 4;
    localparam int unsigned DATA_BITS  = 12;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2,
        ST_READY = 2'd3
    } state_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock divider and half-period counter for one 16-bit ADC frame.
// sclk idles high; the first enabled edge drives it low and starts the frame.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable_i,
    output logic sclk_o,
    output logic sample_c_o,
    output logic frame_done_c_o
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HALF_W = $clog2(2 * FRAME_BITS);

    logic [DIV_W-1:0]  div_q;
    logic [HALF_W-1:0] half_q;
    logic              active_q;
    logic              sclk_q;
    logic              div_last_c;

    assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || !enable_i) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b1;
            div_q    <= '0;
            half_q   <= '0;
        end else if (!active_q) begin
            active_q <= 1'b1;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            half_q   <= '0;
        end else if (div_last_c) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            half_q <= half_q + HALF_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign sclk_o         = sclk_q;
    // Sample on the last system cycle of each high phase.
    assign sample_c_o     = active_q && sclk_q && div_last_c;
    assign frame_done_c_o = sample_c_o && (half_q == HALF_W'(2 * FRAME_BITS - 1));

endmodule

// File: rtl/adc_serial_reader.sv
// 12-bit serial ADC reader with a four-phase done/start handshake.
// Define ADC_FRAME_CHECK_EN to reject frames whose leading bits are non-zero (adds frame_err).
module adc_serial_reader
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned QUIET_CYC = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sdata,
    output logic                 cs_n,
    output logic                 sclk,
    output logic                 done,
    output logic [DATA_BITS-1:0] data,
`ifdef ADC_FRAME_CHECK_EN
    output logic                 frame_err,
`endif
    output logic                 busy
);

    localparam int unsigned QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
`ifdef ADC_FRAME_CHECK_EN
    localparam int unsigned SHIFT_W = FRAME_BITS;
`else
    // Leading bits simply fall off the top of a data-wide shifter.
    localparam int unsigned SHIFT_W = FRAME_BITS - LEAD_BITS;
`endif

    state_t                 state_q;
    logic [QW-1:0]          cnt_q;
    logic [SHIFT_W-1:0]     shift_q;
    logic                   cs_n_q;
    logic                   done_q;
    logic                   busy_q;
    logic [DATA_BITS-1:0]   data_q;

    logic                   sample_c;
    logic                   frame_done_c;
    logic                   cnt_last_c;
    logic                   bad_frame_c;
    logic                   retry_c;
    logic                   conv_en_c;

`ifdef ADC_FRAME_CHECK_EN
    logic                   frame_err_q;
    assign bad_frame_c = |shift_q[FRAME_BITS-1:DATA_BITS];
    assign frame_err   = frame_err_q;
`else
    assign bad_frame_c = 1'b0;
`endif

    assign cnt_last_c = (cnt_q == QW'(QUIET_CYC - 1));
    assign retry_c    = (state_q == ST_QUIET) && cnt_last_c && bad_frame_c;

    // High on every edge that starts or continues a frame, so sclk falls with cs_n.
    assign conv_en_c  = ((state_q == ST_INIT)  && cnt_last_c)
                     || ((state_q == ST_READY) && start)
                     || retry_c
                     || ((state_q == ST_CONV)  && !frame_done_c);

    adc_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clock         (clock),
        .reset         (reset),
        .enable_i      (conv_en_c),
        .sclk_o        (sclk),
        .sample_c_o    (sample_c),
        .frame_done_c_o(frame_done_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            shift_q     <= '0;
            cs_n_q      <= 1'b1;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            data_q      <= '0;
`ifdef ADC_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
`ifdef ADC_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
            if (sample_c) begin
                shift_q <= {shift_q[SHIFT_W-2:0], sdata};
            end
            case (state_q)
                ST_INIT: begin
                    if (cnt_last_c) begin
                        state_q <= ST_CONV;
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + QW'(1);
                    end
                end
                ST_CONV: begin
                    if (frame_done_c) begin
                        state_q <= ST_QUIET;
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b1;
                    end
                end
                ST_QUIET: begin
                    // Final quiet cycle: retry a bad frame, or publish once start is low.
                    if (cnt_last_c) begin
                        if (bad_frame_c) begin
                            state_q     <= ST_CONV;
                            cnt_q       <= '0;
                            cs_n_q      <= 1'b0;
`ifdef ADC_FRAME_CHECK_EN
                            frame_err_q <= 1'b1;
`endif
                        end else if (!start) begin
                            state_q <= ST_READY;
                            data_q  <= shift_q[DATA_BITS-1:0];
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + QW'(1);
                    end
                end
                ST_READY: begin
                    if (start) begin
                        state_q <= ST_CONV;
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign cs_n = cs_n_q;
    assign done = done_q;
    assign busy = busy_q;
    assign data = data_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed/randomised bench for adc_serial_reader with a serial ADC model.
// Covers the ADC_FRAME_CHECK_EN build when that macro is defined.
module tb_adc_serial_reader;

    localparam int CLK_DIV    = 4;
    localparam int QUIET_CYC  = 2;
    localparam int CS_LOW     = 32 * CLK_DIV;
    localparam int PULSE_LAT  = CS_LOW + QUIET_CYC;
    localparam int FIRST_LAT  = QUIET_CYC + CS_LOW + QUIET_CYC;

    logic        clock;
    logic        reset;
    logic        start;
    logic        sdata;
    logic        cs_n;
    logic        sclk;
    logic        done;
    logic [11:0] data;
    logic        busy;
`ifdef ADC_FRAME_CHECK_EN
    logic        frame_err;
`endif

    adc_serial_reader #(
        .CLK_DIV  (CLK_DIV),
        .QUIET_CYC(QUIET_CYC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .sdata    (sdata),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .done     (done),
        .data     (data),
`ifdef ADC_FRAME_CHECK_EN
        .frame_err(frame_err),
`endif
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    logic rst_at_edge = 1'b1;

    always @(posedge clock) begin
        edge_n      <= edge_n + 1;
        rst_at_edge <= reset;
    end

    // ADC model: each 16-bit word goes out MSB first, a new bit after every sclk fall.
    logic [15:0] word_q[$];
    logic [15:0] cur_word = 16'h0;
    int          bit_idx = 16;
    logic        adc_sclk_prev = 1'b1;

    always @(negedge clock) begin
        if (cs_n !== 1'b0) begin
            bit_idx = 16;
        end else if (adc_sclk_prev === 1'b1 && sclk === 1'b0) begin
            if (bit_idx == 16) begin
                if (word_q.size() > 0) cur_word = word_q.pop_front();
                bit_idx = 15;
            end else if (bit_idx > 0) begin
                bit_idx = bit_idx - 1;
            end
            sdata = cur_word[bit_idx];
        end
        adc_sclk_prev = sclk;
    end

    // Interface monitor: frame length, sclk rises, idle levels, busy/done and data stability.
    int   cur_low = 0, cur_rises = 0, last_low = 0, last_rises = 0;
    int   idle_bad = 0, busy_bad = 0, data_bad = 0, err_pulses = 0;
    logic mon_cs_prev = 1'b1, mon_sclk_prev = 1'b1, mon_done_prev = 1'b0;
    logic [11:0] mon_data_prev = 12'h0;

    always @(negedge clock) begin
        if (cs_n === 1'b0) begin
            cur_low = cur_low + 1;
            if (sclk === 1'b1 && mon_sclk_prev === 1'b0) cur_rises = cur_rises + 1;
        end else begin
            if (mon_cs_prev === 1'b0) begin
                last_low   = cur_low;
                last_rises = cur_rises;
            end
            cur_low   = 0;
            cur_rises = 0;
            if (sclk !== 1'b1) idle_bad = idle_bad + 1;
        end
        if (busy !== ~done) busy_bad = busy_bad + 1;
        if (data !== mon_data_prev && !(done === 1'b1 && mon_done_prev === 1'b0) && !rst_at_edge)
            data_bad = data_bad + 1;
`ifdef ADC_FRAME_CHECK_EN
        if (frame_err === 1'b1) err_pulses = err_pulses + 1;
`endif
        mon_cs_prev   = cs_n;
        mon_sclk_prev = sclk;
        mon_done_prev = done;
        mon_data_prev = data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int rise_edge);
        rise_edge = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                rise_edge = edge_n;
                break;
            end
        end
        if (rise_edge < 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $error("FAIL done_timeout: done still %b after %0d cycles, expected 1", done, budget);
        end
    endtask

    function automatic logic [15:0] rand_word();
        return 16'($urandom_range(1, 4095));
    endfunction

    initial begin
        int r_edge, n_edge, rise, hits, busy_low, gap;
        logic [15:0] w, w2;

        reset = 1'b1;
        start = 1'b0;
        sdata = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_sclk", 32'(sclk), 1);
        check("rst_done", 32'(done), 0);
        check("rst_data", 32'(data), 0);
        check("rst_busy", 32'(busy), 1);

        // Automatic first conversion after reset.
        w = 16'h0ABC;
        word_q.push_back(w);
        reset  = 1'b0;
        r_edge = edge_n;
        wait_done(400, rise);
        check("auto_done_edge", 32'(rise), 32'(r_edge + FIRST_LAT));
        check("auto_data", 32'(data), 32'(w[11:0]));
        check("auto_cs_low", 32'(last_low), 32'(CS_LOW));
        check("auto_rises", 32'(last_rises), 16);

        // Single-cycle start pulse.
        w = 16'h0FFF;
        word_q.push_back(w);
        @(negedge clock);
        start  = 1'b1;
        n_edge = edge_n + 1;
        @(negedge clock);
        start = 1'b0;
        check("pulse_done_fall", 32'(done), 0);
        check("pulse_cs_n", 32'(cs_n), 0);
        check("pulse_data_held", 32'(data), 32'h0ABC);
        wait_done(400, rise);
        check("pulse_done_edge", 32'(rise), 32'(n_edge + PULSE_LAT));
        check("pulse_data", 32'(data), 32'(w[11:0]));

        // start held high well past the end of the frame.
        w = rand_word();
        word_q.push_back(w);
        @(negedge clock);
        start  = 1'b1;
        n_edge = edge_n + 1;
        hits   = 0;
        while (edge_n < n_edge + 199) begin
            @(negedge clock);
            if (done === 1'b1) hits = hits + 1;
        end
        start = 1'b0;
        check("hold_no_done", 32'(hits), 0);
        wait_done(20, rise);
        check("hold_done_edge", 32'(rise), 32'(n_edge + 200));
        check("hold_data", 32'(data), 32'(w[11:0]));

        // Random words with start toggling during the conversion.
        for (int it = 0; it < 4; it++) begin
            w = rand_word();
            word_q.push_back(w);
            gap = int'($urandom_range(0, 5));
            repeat (gap) @(negedge clock);
            @(negedge clock);
            start  = 1'b1;
            n_edge = edge_n + 1;
            @(negedge clock);
            start    = 1'b0;
            busy_low = 0;
            repeat (100) begin
                @(negedge clock);
                if (busy !== 1'b1) busy_low = busy_low + 1;
                start = 1'($urandom_range(0, 1));
            end
            start = 1'b0;
            check("toggle_busy", 32'(busy_low), 0);
            wait_done(100, rise);
            check("toggle_done_edge", 32'(rise), 32'(n_edge + PULSE_LAT));
            check("toggle_data", 32'(data), 32'(w[11:0]));
            check("toggle_cs_low", 32'(last_low), 32'(CS_LOW));
            check("toggle_rises", 32'(last_rises), 16);
        end

        // Reset in the middle of a frame.
        w  = rand_word();
        w2 = rand_word();
        word_q.push_back(w);
        word_q.push_back(w2);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cur_rises == 7 && sclk === 1'b0) break;
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        check("midrst_cs_n", 32'(cs_n), 1);
        check("midrst_sclk", 32'(sclk), 1);
        check("midrst_done", 32'(done), 0);
        check("midrst_data", 32'(data), 0);
        check("midrst_busy", 32'(busy), 1);
        reset  = 1'b0;
        r_edge = edge_n;
        wait_done(400, rise);
        check("midrst_done_edge", 32'(rise), 32'(r_edge + FIRST_LAT));
        check("midrst_data_new", 32'(data), 32'(w2[11:0]));
        check("midrst_rises", 32'(last_rises), 16);

`ifdef ADC_FRAME_CHECK_EN
        // Bad leading bits: one error pulse, automatic retry, then the good word.
        word_q.push_back(16'h5123);
        word_q.push_back(16'h0123);
        hits = err_pulses;
        @(negedge clock);
        start  = 1'b1;
        n_edge = edge_n + 1;
        @(negedge clock);
        start = 1'b0;
        wait_done(600, rise);
        check("ferr_done_edge", 32'(rise), 32'(n_edge + PULSE_LAT + CS_LOW + QUIET_CYC));
        check("ferr_data", 32'(data), 32'h123);
        check("ferr_pulses", 32'(err_pulses - hits), 1);
`else
        // Leading bits are ignored when the frame check is not built in.
        w = 16'hF5C3;
        word_q.push_back(w);
        @(negedge clock);
        start  = 1'b1;
        n_edge = edge_n + 1;
        @(negedge clock);
        start = 1'b0;
        wait_done(400, rise);
        check("lead_done_edge", 32'(rise), 32'(n_edge + PULSE_LAT));
        check("lead_data", 32'(data), 32'h5C3);
`endif

        repeat (3) @(negedge clock);
        check("mon_sclk_idle", 32'(idle_bad), 0);
        check("mon_busy_done", 32'(busy_bad), 0);
        check("mon_data_stable", 32'(data_bad), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
